cdr_lock_detect: RTL and testbench
==================================

# cdr_lock_detect

Digital lock detector for the CDR loop. Sits beside the charge pump on the phase-frequency detector outputs and consumes the same `up`/`down` pulses. Synchronises them into the `refclk` domain, measures per-window correction activity, and runs an acquire/check/locked state machine. Outputs `locked`, a one-cycle `lock_lost` pulse, and a frequency-direction hint for loop supervision.

## Interface
Parameters:
- `WIN_LEN`, 64: window length in `refclk` cycles; must be ≥ 2.
- `CNT_W`, 7: width of the per-window counters; must satisfy 2^CNT_W > WIN_LEN.
- `LOCK_THR`, 4: a window is "quiet" if activity ≤ LOCK_THR.
- `UNLOCK_THR`, 16: in LOCKED, activity > UNLOCK_THR drops lock; must be ≥ LOCK_THR.
- `LOCK_WINS`, 4: consecutive quiet windows required to lock; must be ≥ 1.
- `SYNC_STAGES`, 2: flops in each input synchroniser; must be ≥ 2.

Ports:
- `refclk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `up`, in, 1: PFD up pulse, asynchronous to `refclk`.
- `down`, in, 1: PFD down pulse, asynchronous to `refclk`.
- `locked`, out, 1: high while the state is LOCKED.
- `lock_lost`, out, 1: one-cycle pulse on the LOCKED→ACQ transition.
- `freq_hint`, out, 2: result of the last window. 01 = up dominant, 10 = down dominant, 00 = balanced or none.
- `activity`, out, CNT_W: activity count of the last completed window.

## Operation
- Each of `up` and `down` passes through its own SYNC_STAGES-flop synchroniser, giving `up_s` and `dn_s`.
- Window counter `win` runs 0..WIN_LEN-1 and wraps.
- Per-cycle counters:
  - `act_acc` increments when `up_s | dn_s`.
  - `up_acc` increments when `up_s`.
  - `dn_acc` increments when `dn_s`.
  - If both inputs are high in the same cycle, `act_acc` increments once, and `up_acc` and `dn_acc` each increment.
- Counters cannot overflow because each is bounded by WIN_LEN.
- End of window is the cycle with `win == WIN_LEN-1`. The evaluation includes that cycle's sample. In that same cycle:
  - all accumulators clear to 0;
  - `activity` loads the final count;
  - `freq_hint` loads from `up_acc` vs `dn_acc`, with equality giving 00.
- States are ACQ, CHECK and LOCKED, with a quiet-window counter `qcnt`. Transitions happen only at end of window:
  - ACQ, quiet window: go to CHECK with `qcnt`=1. If LOCK_WINS==1, go directly to LOCKED. Otherwise stay in ACQ.
  - CHECK, quiet window: `qcnt`++. When `qcnt` reaches LOCK_WINS, go to LOCKED. A non-quiet window sends the block to ACQ with `qcnt`=0.
  - LOCKED, activity > UNLOCK_THR: go to ACQ, assert `lock_lost`, clear `qcnt`. Otherwise stay in LOCKED; activity in (LOCK_THR, UNLOCK_THR] is hysteresis.
- Reset, at any time including mid-window:
  - state = ACQ, `qcnt`=0, `win`=0;
  - all accumulators 0, synchroniser flops 0;
  - `locked`=0, `lock_lost`=0, `freq_hint`=00, `activity`=0.

## Timing
- Input to accumulator latency: SYNC_STAGES cycles. A level on `up` first counts SYNC_STAGES cycles after capture.
- State, `locked`, `activity` and `freq_hint` are registered. They update on the edge that ends the cycle where `win == WIN_LEN-1`.
- Minimum time from reset release to `locked`=1 is LOCK_WINS × WIN_LEN cycles.
- `lock_lost` is high for exactly one cycle, coincident with the first cycle `locked`=0.
- Pulses shorter than one `refclk` period may be missed. This is accepted; the block measures activity statistically, not exactly.

## Configuration
- `CDR_LD_STATS_EN` defined:
  - adds output `relock_cnt` (out, 16): increments on every entry to LOCKED;
  - adds output `unlock_cnt` (out, 16): increments on every `lock_lost`;
  - both saturate at 16'hFFFF and reset to 0.
- Not defined: both ports and their logic are absent. All other behaviour is identical.

## Test plan
- Default parameters, `up`=`down`=0 from reset → `locked` rises after exactly 256 cycles; `activity`=0; `freq_hint`=00.
- `up` held high 10 cycles per window for 3 windows, then quiet → not locked until 4 further quiet windows; ACQ→CHECK occurs only in the first quiet window.
- Locked, then one window with `down` high 20 cycles → `lock_lost` pulses once, `locked`=0, `activity`=20, `freq_hint`=10. One window at 12 cycles instead → `locked` stays 1.
- `up` and `down` both high the same 8 cycles in a window → `activity`=8, `freq_hint`=00.
- `rst` asserted at `win`=30 while in CHECK with `qcnt`=3 → all outputs 0 immediately; relock needs a full 256 quiet cycles.
- With `CDR_LD_STATS_EN`: lock, lose, relock → `relock_cnt`=2, `unlock_cnt`=1.

Source files
------------

// File: rtl/cdr_lock_detect_if.sv
// Signal bundle between the CDR lock detector and its loop supervisor.
// The CDR_LD_STATS_EN macro adds the relock/unlock event counters.
`timescale 1ns/1ps

interface cdr_lock_detect_if #(
    parameter int CNT_W = 7
) ();
    logic             up;
    logic             down;
    logic             locked;
    logic             lock_lost;
    logic [1:0]       freq_hint;
    logic [CNT_W-1:0] activity;
`ifdef CDR_LD_STATS_EN
    logic [15:0]      relock_cnt;
    logic [15:0]      unlock_cnt;
`endif

    modport master (
        output up, down,
        input  locked, lock_lost, freq_hint, activity
`ifdef CDR_LD_STATS_EN
        , input relock_cnt, unlock_cnt
`endif
    );

    modport slave (
        input  up, down,
        output locked, lock_lost, freq_hint, activity
`ifdef CDR_LD_STATS_EN
        , output relock_cnt, unlock_cnt
`endif
    );
endinterface

// File: rtl/cdr_lock_detect.sv
// CDR digital lock detector: synchronised PFD up/down activity per window drives an ACQ/CHECK/LOCKED FSM.
// Optional feature macro: CDR_LD_STATS_EN (adds saturating relock/unlock event counters).
`timescale 1ns/1ps

//  state     | meaning
//  ST_ACQ    | acquiring; waiting for the first quiet window
//  ST_CHECK  | counting consecutive quiet windows in r_qcnt
//  ST_LOCKED | locked; drops back to ST_ACQ only above UNLOCK_THR
module cdr_lock_detect #(
    parameter int WIN_LEN     = 64,
    parameter int CNT_W       = 7,
    parameter int LOCK_THR    = 4,
    parameter int UNLOCK_THR  = 16,
    parameter int LOCK_WINS   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_refclk,
    input  logic              i_rst,
    cdr_lock_detect_if.slave  bus
);
    localparam int QW = (LOCK_WINS < 2) ? 1 : $clog2(LOCK_WINS + 1);

    localparam logic [CNT_W-1:0] LP_WIN_LAST   = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] LP_LOCK_THR   = CNT_W'(LOCK_THR);
    localparam logic [CNT_W-1:0] LP_UNLOCK_THR = CNT_W'(UNLOCK_THR);
    localparam logic [QW-1:0]    LP_QMAX       = QW'(LOCK_WINS);

    typedef enum logic [1:0] {
        ST_ACQ    = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_up_sync;
    logic [SYNC_STAGES-1:0] r_dn_sync;
    logic [CNT_W-1:0]       r_win;
    logic [CNT_W-1:0]       r_act_acc;
    logic [CNT_W-1:0]       r_up_acc;
    logic [CNT_W-1:0]       r_dn_acc;
    logic [CNT_W-1:0]       r_activity;
    logic [1:0]             r_freq_hint;
    logic                   r_lock_lost;
    state_t                 r_state;
    logic [QW-1:0]          r_qcnt;

    logic                   w_up_s;
    logic                   w_dn_s;
    logic                   w_eow;
    logic [CNT_W-1:0]       w_act_next;
    logic [CNT_W-1:0]       w_up_next;
    logic [CNT_W-1:0]       w_dn_next;
    logic                   w_quiet;
    logic [QW-1:0]          w_qinc;
    state_t                 w_state_next;
    logic [QW-1:0]          w_qcnt_next;
    logic                   w_lose;

    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) begin
            r_up_sync <= '0;
            r_dn_sync <= '0;
        end else begin
            r_up_sync <= {r_up_sync[SYNC_STAGES-2:0], bus.up};
            r_dn_sync <= {r_dn_sync[SYNC_STAGES-2:0], bus.down};
        end
    end

    assign w_up_s = r_up_sync[SYNC_STAGES-1];
    assign w_dn_s = r_dn_sync[SYNC_STAGES-1];
    assign w_eow  = (r_win == LP_WIN_LAST);

    // The end-of-window evaluation must include the sample taken in that same cycle.
    assign w_act_next = r_act_acc + {{(CNT_W-1){1'b0}}, (w_up_s | w_dn_s)};
    assign w_up_next  = r_up_acc  + {{(CNT_W-1){1'b0}}, w_up_s};
    assign w_dn_next  = r_dn_acc  + {{(CNT_W-1){1'b0}}, w_dn_s};
    assign w_quiet    = (w_act_next <= LP_LOCK_THR);
    assign w_qinc     = r_qcnt + QW'(1);

    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) begin
            r_win       <= '0;
            r_act_acc   <= '0;
            r_up_acc    <= '0;
            r_dn_acc    <= '0;
            r_activity  <= '0;
            r_freq_hint <= 2'b00;
        end else if (w_eow) begin
            r_win       <= '0;
            r_act_acc   <= '0;
            r_up_acc    <= '0;
            r_dn_acc    <= '0;
            r_activity  <= w_act_next;
            if (w_up_next > w_dn_next) begin
                r_freq_hint <= 2'b01;
            end else if (w_dn_next > w_up_next) begin
                r_freq_hint <= 2'b10;
            end else begin
                r_freq_hint <= 2'b00;
            end
        end else begin
            r_win     <= r_win + CNT_W'(1);
            r_act_acc <= w_act_next;
            r_up_acc  <= w_up_next;
            r_dn_acc  <= w_dn_next;
        end
    end

    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_ACQ;
            r_qcnt      <= '0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_qcnt      <= w_qcnt_next;
            r_lock_lost <= w_lose;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_qcnt_next  = r_qcnt;
        w_lose       = 1'b0;
        if (w_eow) begin
            case (r_state)
                ST_ACQ: begin
                    if (w_quiet) begin
                        w_qcnt_next  = QW'(1);
                        w_state_next = (LOCK_WINS == 1) ? ST_LOCKED : ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_quiet) begin
                        w_qcnt_next = w_qinc;
                        if (w_qinc >= LP_QMAX) begin
                            w_state_next = ST_LOCKED;
                        end
                    end else begin
                        w_qcnt_next  = '0;
                        w_state_next = ST_ACQ;
                    end
                end
                ST_LOCKED: begin
                    // Activity between the two thresholds is tolerated while locked.
                    if (w_act_next > LP_UNLOCK_THR) begin
                        w_qcnt_next  = '0;
                        w_state_next = ST_ACQ;
                        w_lose       = 1'b1;
                    end
                end
                default: begin
                    w_qcnt_next  = '0;
                    w_state_next = ST_ACQ;
                end
            endcase
        end
    end

    assign bus.locked    = (r_state == ST_LOCKED);
    assign bus.lock_lost = r_lock_lost;
    assign bus.freq_hint = r_freq_hint;
    assign bus.activity  = r_activity;

`ifdef CDR_LD_STATS_EN
    logic [15:0] r_relock_cnt;
    logic [15:0] r_unlock_cnt;
    logic        w_enter_lock;

    assign w_enter_lock = (w_state_next == ST_LOCKED) && (r_state != ST_LOCKED);

    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) begin
            r_relock_cnt <= '0;
            r_unlock_cnt <= '0;
        end else begin
            if (w_enter_lock && (r_relock_cnt != 16'hFFFF)) begin
                r_relock_cnt <= r_relock_cnt + 16'd1;
            end
            if (w_lose && (r_unlock_cnt != 16'hFFFF)) begin
                r_unlock_cnt <= r_unlock_cnt + 16'd1;
            end
        end
    end

    assign bus.relock_cnt = r_relock_cnt;
    assign bus.unlock_cnt = r_unlock_cnt;
`endif

endmodule

// File: tb/tb_cdr_lock_detect.sv
// Directed-vector bench for cdr_lock_detect at default parameters; windows are driven in step with the DUT window counter.
`timescale 1ns/1ps

module tb_cdr_lock_detect;
    logic clk_sys;
    logic rst;
    int   n_vec;
    int   n_err;

    cdr_lock_detect_if #(.CNT_W(7)) bus ();

    cdr_lock_detect #(
        .WIN_LEN(64), .CNT_W(7), .LOCK_THR(4), .UNLOCK_THR(16),
        .LOCK_WINS(4), .SYNC_STAGES(2)
    ) dut (
        .i_refclk (clk_sys),
        .i_rst    (rst),
        .bus      (bus.slave)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // n cycles; up high for cycle offsets [u0,u1), down for [d0,d1); ends 1ns after the last edge.
    task automatic win_run(input int n, input int u0, input int u1, input int d0, input int d1);
        for (int c = 0; c < n; c++) begin
            bus.up   = (c >= u0) && (c < u1);
            bus.down = (c >= d0) && (c < d1);
            @(posedge clk_sys);
            #1;
        end
        bus.up   = 1'b0;
        bus.down = 1'b0;
    endtask

    task automatic quiet(input int wins);
        for (int w = 0; w < wins; w++) win_run(64, 0, 0, 0, 0);
    endtask

    task automatic chk_out(input string tag, input int lk, input int ll, input int act, input int fh);
        chk({tag, "_locked"},    int'(bus.locked),    lk);
        chk({tag, "_lock_lost"}, int'(bus.lock_lost), ll);
        chk({tag, "_activity"},  int'(bus.activity),  act);
        chk({tag, "_freq_hint"}, int'(bus.freq_hint), fh);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        bus.up   = 1'b0;
        bus.down = 1'b0;
        rst      = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        chk_out("reset", 0, 0, 0, 0);
        @(negedge clk_sys);
        rst = 1'b0;

        // Quiet from reset: lock exactly 256 cycles after release.
        quiet(3);
        chk("acq_192_locked", int'(bus.locked), 0);
        win_run(63, 0, 0, 0, 0);
        chk("acq_255_locked", int'(bus.locked), 0);
        win_run(1, 0, 0, 0, 0);
        chk_out("acq_256", 1, 0, 0, 0);

        // Down for 20 cycles loses lock with a single-cycle pulse.
        win_run(64, 0, 0, 0, 20);
        chk_out("lose20", 0, 1, 20, 2);
        win_run(1, 0, 0, 0, 0);
        chk("lose20_pulse_end", int'(bus.lock_lost), 0);
        chk("lose20_still_unlocked", int'(bus.locked), 0);
        win_run(63, 0, 0, 0, 0);

        // Three noisy windows keep ACQ; then four quiet windows are needed.
        for (int k = 0; k < 3; k++) begin
            win_run(64, 0, 10, 0, 0);
            chk_out("noisy10", 0, 0, 10, 1);
        end
        quiet(3);
        chk("noisy_q3_locked", int'(bus.locked), 0);
        quiet(1);
        chk_out("noisy_q4", 1, 0, 0, 0);

        // Hysteresis band and direction hints while locked.
        win_run(64, 0, 0, 0, 12);
        chk_out("hyst12", 1, 0, 12, 2);
        win_run(64, 0, 8, 0, 8);
        chk_out("both8", 1, 0, 8, 0);
        win_run(64, 0, 5, 10, 13);
        chk_out("up5dn3", 1, 0, 8, 1);
        win_run(64, 0, 16, 0, 0);
        chk_out("edge16", 1, 0, 16, 1);
        win_run(64, 0, 17, 0, 0);
        chk_out("edge17", 0, 1, 17, 1);

        // Activity of exactly 4 is quiet; 5 breaks the quiet run.
        win_run(64, 0, 4, 0, 0);
        win_run(64, 0, 4, 0, 0);
        win_run(64, 0, 5, 0, 0);
        chk_out("act5", 0, 0, 5, 1);
        for (int k = 0; k < 3; k++) win_run(64, 0, 4, 0, 0);
        chk_out("act4_q3", 0, 0, 4, 1);
        win_run(64, 0, 4, 0, 0);
        chk_out("act4_q4", 1, 0, 4, 1);

        // Reset mid-window while in CHECK with three quiet windows counted.
        win_run(64, 0, 0, 20, 40);
        chk_out("lose_pre_rst", 0, 1, 20, 2);
        for (int k = 0; k < 3; k++) win_run(64, 0, 3, 0, 0);
        chk_out("check_q3", 0, 0, 3, 1);
        win_run(30, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk_out("mid_rst", 0, 0, 0, 0);
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        rst = 1'b0;
        quiet(3);
        win_run(63, 0, 0, 0, 0);
        chk("relock_255_locked", int'(bus.locked), 0);
        win_run(1, 0, 0, 0, 0);
        chk("relock_256_locked", int'(bus.locked), 1);

`ifdef CDR_LD_STATS_EN
        chk("stats_relock_a", int'(bus.relock_cnt), 1);
        chk("stats_unlock_a", int'(bus.unlock_cnt), 0);
        win_run(64, 0, 20, 0, 0);
        chk("stats_lost", int'(bus.lock_lost), 1);
        quiet(4);
        chk("stats_relocked", int'(bus.locked), 1);
        chk("stats_relock_b", int'(bus.relock_cnt), 2);
        chk("stats_unlock_b", int'(bus.unlock_cnt), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
